// File: rtl/ysyx_22041412_booth_seq_mul.sv
// ysyx_22041412_booth_seq_mul: sequential radix-4 Booth multiplier returning the full 2*XLEN product
//   clk, rst (async, active-high)
//   in_valid/in_ready      : operand handshake (multiplicand, multiplier, a_signed, b_signed)
//   flush                  : synchronous abort of any in-flight operation
//   out_valid/out_ready    : result handshake (result_hi, result_lo)
module ysyx_22041412_booth_seq_mul #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            a_signed,
  input  logic            b_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);
  localparam int STEPS = (XLEN + 2) / 2;
  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  // a_sh holds the extended multiplicand already shifted by 2i; b_sh holds the
  // extended multiplier with y[-1] appended, shifted so the window is always b_sh[2:0]
  logic [2*XLEN-1:0] a_sh, acc, pp_mag, pp, sum;
  logic [XLEN+2:0] b_sh;
  logic [2:0] w;
  logic neg, two, zero, accept, last;
  assign accept = in_valid & in_ready & ~flush;
  assign last = (state == BUSY) && (cnt == LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else if (state == IDLE) state_nxt = accept ? BUSY : IDLE;
    else if (state == BUSY) state_nxt = last ? DONE : BUSY;
    else state_nxt = out_ready ? IDLE : DONE;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  assign w = b_sh[2:0];
  assign zero = (w == 3'b000) || (w == 3'b111);
  assign two = (w == 3'b011) || (w == 3'b100);
  assign neg = w[2] & ~(w[1] & w[0]);
  assign pp_mag = zero ? '0 : two ? a_sh << 1 : a_sh;
  assign pp = neg ? ~pp_mag + 1'b1 : pp_mag;
  assign sum = acc + pp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
      acc <= '0;
      a_sh <= {{XLEN{a_signed & multiplicand[XLEN-1]}}, multiplicand};
      b_sh <= {{2{b_signed & multiplier[XLEN-1]}}, multiplier, 1'b0};
    end else if (state == BUSY) begin
      cnt <= last ? '0 : cnt + CW'(1);
      acc <= sum;
      a_sh <= a_sh << 2;
      b_sh <= b_sh >> 2;
      if (last) {result_hi, result_lo} <= sum;
    end
endmodule

// File: tb/tb_ysyx_22041412_booth_seq_mul.sv
// tb_ysyx_22041412_booth_seq_mul: directed and random checks of the Booth multiplier against an arithmetic model
module tb_ysyx_22041412_booth_seq_mul;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, flush = 0, a_signed = 0, b_signed = 0;
  logic out_valid, out_ready = 0;
  logic [63:0] multiplicand = 0, multiplier = 0, result_hi, result_lo;
  int cmp = 0, errs = 0;
  always #5 clk = ~clk;
  ysyx_22041412_booth_seq_mul #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .a_signed(a_signed), .b_signed(b_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .out_valid(out_valid), .out_ready(out_ready), .result_hi(result_hi), .result_lo(result_lo)
  );
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic as, input logic bs);
    logic signed [129:0] sa, sb, p;
    sa = as ? $signed({{66{a[63]}}, a}) : $signed({66'b0, a});
    sb = bs ? $signed({{66{b[63]}}, b}) : $signed({66'b0, b});
    p = sa * sb;
    return p[127:0];
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [63:0] a, input logic [63:0] b, input logic as, input logic bs);
    @(negedge clk);
    multiplicand = a; multiplier = b; a_signed = as; b_signed = bs; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic as, input logic bs, input logic [127:0] exp);
    int n;
    start(a, b, as, bs);
    wait_done(n);
    chk({tag, "_latency"}, 128'(n), 128'd33);
    chk(tag, {result_hi, result_lo}, exp);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_to_idle"}, {126'b0, out_valid, in_ready}, 128'b01);
  endtask
  initial begin
    int n;
    logic seen;
    logic [127:0] held;
    logic [63:0] ra, rb;
    logic ras, rbs;
    #12;
    chk("reset", {125'b0, out_valid, in_ready, |{result_hi, result_lo}}, 128'b010);
    @(negedge clk);
    rst = 0;
    mul("u3x5", 64'd3, 64'd5, 0, 0, 128'd15);
    mul("s_m1xm1", '1, '1, 1, 1, 128'd1);
    mul("u_m1xm1", '1, '1, 0, 0, {64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
    mul("s_minxm1", 64'h8000_0000_0000_0000, '1, 1, 1, {64'd0, 64'h8000_0000_0000_0000});
    mul("su_minx2", 64'h8000_0000_0000_0000, 64'd2, 1, 0, {64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
    // backpressure: result held, new operands ignored
    start(64'd123456789, 64'd987654321, 0, 0);
    wait_done(n);
    chk("bp_latency", 128'(n), 128'd33);
    held = {result_hi, result_lo};
    chk("bp_result", held, ref_mul(64'd123456789, 64'd987654321, 0, 0));
    multiplicand = 64'd11; multiplier = 64'd13; in_valid = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || {result_hi, result_lo} !== held) seen = 1;
    end
    chk("bp_hold", 128'(seen), 128'd0);
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_release", {126'b0, out_valid, in_ready}, 128'b01);
    // flush mid-BUSY
    start(64'd99, 64'd77, 0, 0);
    repeat (17) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", {126'b0, out_valid, in_ready}, 128'b01);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_busy_quiet", 128'(seen), 128'd0);
    // flush in DONE beats out_ready and in_valid
    start(64'd5, 64'd9, 0, 0);
    wait_done(n);
    chk("flush_done_latency", 128'(n), 128'd33);
    flush = 1; out_ready = 1; in_valid = 1;
    @(negedge clk);
    flush = 0; out_ready = 0; in_valid = 0;
    chk("flush_done", {126'b0, out_valid, in_ready}, 128'b01);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_no_accept", 128'(seen), 128'd0);
    mul("post_flush_7x6", 64'd7, 64'd6, 1, 1, 128'd42);
    // asynchronous reset between edges while BUSY
    start(64'd1000, 64'd1000, 0, 0);
    repeat (10) @(negedge clk);
    #2 rst = 1;
    #1 chk("async_rst", {125'b0, out_valid, in_ready, |{result_hi, result_lo}}, 128'b010);
    @(negedge clk);
    rst = 0;
    mul("post_rst_2x3", 64'd2, 64'd3, 0, 0, 128'd6);
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 6 == 0) ra = {1'b1, 63'b0};
      if (i % 8 == 1) rb = '1;
      ras = 1'($urandom);
      rbs = ras ? 1'($urandom) : 1'b0;
      mul("rand", ra, rb, ras, rbs, ref_mul(ra, rb, ras, rbs));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/ysyx_22041412_booth_seq_mul.md
Name: ysyx_22041412_booth_seq_mul

Overview:
Sequential radix-4 Booth multiplier for the M-extension MUL/MULH/MULHSU/MULHU path. It is the encoder/controller side of the Booth partial-product scheme. Each cycle it scans one 3-bit window of the multiplier, derives the neg/zero/one/two selector, and forms the selected partial product of the multiplicand. It accumulates that product into a 2*XLEN result and returns the full product to the EXU through a valid/ready handshake.

Parameters:
XLEN, 64, operand width; the result is 2*XLEN bits.
STEPS, (XLEN+2)/2, number of Booth iterations (33 for XLEN=64); derived, never overridden.

Ports:
clk  input  1  clock, all state rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
flush  input  1  synchronous abort of any in-flight operation (pipeline flush).
a_signed  input  1  multiplicand is signed.
b_signed  input  1  multiplier is signed.
multiplicand  input  XLEN  operand A.
multiplier  input  XLEN  operand B.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result_hi  output  XLEN  product bits [2*XLEN-1:XLEN].
result_lo  output  XLEN  product bits [XLEN-1:0].

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0.
  - result_hi=0, result_lo=0; accumulator, step counter and operand registers cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch the operands and go to BUSY with counter=0 and accumulator=0.
  - BUSY: in_ready=0. Perform one Booth step per cycle. After step STEPS-1, load result_hi/lo from the final sum and go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE with out_valid=0.
- Operand latch:
  - A is extended to XLEN+2 bits: sign-extended if a_signed, else zero-extended.
  - B is extended the same way using b_signed, with an implicit bit y[-1]=0 appended.
- Step i (i=0..STEPS-1) examines {y[2i+1], y[2i], y[2i-1]}:
  - 000, 111: zero.
  - 001, 010: +A (one).
  - 011: +2A (two).
  - 100: -2A (neg, two).
  - 101, 110: -A (neg, one).
- Partial product:
  - A, or A<<1, is sign-extended to 2*XLEN+4 bits.
  - If neg, the product is two's-complemented (invert +1).
  - It is shifted left by 2i and added to the accumulator. Arithmetic is modulo 2^(2*XLEN); overflow beyond 2*XLEN bits is discarded.
- Latency: the accept edge, then STEPS BUSY cycles. out_valid rises on the STEPS-th edge after accept (33 for XLEN=64).
- Output hold:
  - result_hi/lo and out_valid stay stable while out_valid=1 and out_ready=0.
  - Results change only on BUSY→DONE.
- Single issue: no new accept until the result handshake completes. The same-cycle accept after out_ready is not allowed; the FSM passes through IDLE first.
- flush:
  - Forces state=IDLE, out_valid=0, counter=0 on the next edge from any state.
  - A result in DONE is discarded.
  - flush has priority over in_valid and out_ready in the same cycle; no accept happens during a flush cycle.
  - result_hi/lo keep their old values (don't-care while out_valid=0).
- Reset mid-operation: immediate IDLE regardless of state; the partial accumulator is discarded.
- Signedness table:
  - MUL/MULH: a_signed=1, b_signed=1.
  - MULHSU: a_signed=1, b_signed=0.
  - MULHU: both 0.
- The full 128-bit product is returned in every case. The EXU selects result_lo or result_hi.
- in_valid while BUSY/DONE is ignored; operands are not latched.

Test Plan:
- Unsigned 3 × 5 (a_signed=b_signed=0) → after 33 cycles out_valid=1, result_hi=0, result_lo=15.
- Signed -1 × -1 (0xFFFF_FFFF_FFFF_FFFF both, signed) → result_hi=0, result_lo=1. Same operands unsigned → result_hi=0xFFFF_FFFF_FFFF_FFFE, result_lo=1.
- Signed 0x8000_0000_0000_0000 × -1 → result_hi=0, result_lo=0x8000_0000_0000_0000. MULHSU with 0x8000_0000_0000_0000 (signed) × 2 → result_hi=0xFFFF_FFFF_FFFF_FFFF, result_lo=0.
- Backpressure: hold out_ready=0 for 10 cycles after completion → out_valid and result remain constant, in_ready=0, and a new in_valid is ignored. Raise out_ready → IDLE next cycle, in_ready=1.
- flush at BUSY step 17, and flush in DONE with out_ready=1 in the same cycle → out_valid=0 next edge, IDLE. The following 7×6 multiply completes normally with result_lo=42.
- Assert rst asynchronously mid-BUSY (between edges) → out_valid=0, in_ready=1, result=0 immediately. After release, a 2 × 3 multiply returns 6.
